// File: rtl/fifo_read_ctrl_pkg.sv
// Shared sizing for the audio sample FIFO; imported by both the write-side and read-side logic.
package fifo_read_ctrl_pkg;
  localparam int FIFO_ADDR_W    = 4;
  localparam int FIFO_PTR_W     = FIFO_ADDR_W + 1;
  localparam int FIFO_DEPTH     = 2 ** FIFO_ADDR_W;
  localparam int FIFO_AE_THRESH = 2;
endpackage

// File: rtl/fifo_read_ctrl_status.sv
// Pointer compare: empty/full/level/almost_empty from the registered read and write pointers.
module fifo_status #(
  parameter int ADDR_W    = 4,
  parameter int AE_THRESH = 2
) (
  input  logic [ADDR_W:0] rptr,
  input  logic [ADDR_W:0] wptr,
  output logic            fifo_empty,
  output logic            fifo_full,
  output logic            almost_empty,
  output logic [ADDR_W:0] level
);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W + 1)'(AE_THRESH);

  // Wrap bits differ with equal addresses only when the writer is a full lap ahead.
  assign fifo_empty   = (rptr == wptr);
  assign fifo_full    = (rptr[ADDR_W] != wptr[ADDR_W]) &&
                        (rptr[ADDR_W-1:0] == wptr[ADDR_W-1:0]);
  assign level        = wptr - rptr;
  assign almost_empty = (level <= AE_LVL);
endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller: read pointer, empty gating, read-data valid strobe and sticky underflow.
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AE_THRESH = FIFO_AE_THRESH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd,
  input  logic [ADDR_W:0] wptr,
  input  logic            clr_err,
  output logic [ADDR_W:0] rptr,
  output logic            fifo_re,
  output logic            fifo_empty,
  output logic            fifo_full,
  output logic            almost_empty,
  output logic [ADDR_W:0] level,
  output logic            dout_valid,
  output logic            underflow
);
  fifo_status #(.ADDR_W(ADDR_W), .AE_THRESH(AE_THRESH)) u_status (
    .rptr         (rptr),
    .wptr         (wptr),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_empty (almost_empty),
    .level        (level)
  );

  assign fifo_re = rd & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr       <= '0;
      dout_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (fifo_re) rptr <= rptr + (ADDR_W + 1)'(1);
      // RAM is registered-read: data appears one clock after the enable.
      dout_valid <= fifo_re;
      // A fresh underflow wins over a clear in the same cycle.
      if (rd && fifo_empty) underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed checks of fifo_read_ctrl plus a randomized occupancy-model run.
module tb_fifo_read_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd = 1'b0;
  logic [4:0] wptr = '0;
  logic       clr_err = 1'b0;
  logic [4:0] rptr, level;
  logic       fifo_re, fifo_empty, fifo_full, almost_empty, dout_valid, underflow;

  int checks = 0;
  int errors = 0;

  fifo_read_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd           (rd),
    .wptr         (wptr),
    .clr_err      (clr_err),
    .rptr         (rptr),
    .fifo_re      (fifo_re),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_empty (almost_empty),
    .level        (level),
    .dout_valid   (dout_valid),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_n(input int n);
    rd = 1'b1;
    repeat (n) step();
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rd = 1'b0; clr_err = 1'b0; wptr = '0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  int   occ, exp_rptr;
  logic r, w, prev_re, exp_re;

  initial begin
    // Reset state
    #1;
    chk("rst_rptr", 32'(rptr), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_re", 32'(fifo_re), 0);
    chk("rst_dv", 32'(dout_valid), 0);
    chk("rst_uf", 32'(underflow), 0);
    rst_n = 1'b1;
    step();

    // Asynchronous reset mid-stream at rptr=7, wptr=12
    wptr = 5'd12;
    rd_n(7);
    chk("pre_rptr", 32'(rptr), 7);
    chk("pre_dv", 32'(dout_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rptr", 32'(rptr), 0);
    chk("arst_dv", 32'(dout_valid), 0);
    chk("arst_uf", 32'(underflow), 0);
    wptr = '0;
    #1;
    chk("arst_empty", 32'(fifo_empty), 1);
    rst_n = 1'b1;
    step();

    // Single read
    wptr = 5'd3;
    rd = 1'b1;
    #1;
    chk("sr_re", 32'(fifo_re), 1);
    chk("sr_level", 32'(level), 3);
    chk("sr_dv0", 32'(dout_valid), 0);
    step();
    rd = 1'b0;
    chk("sr_rptr", 32'(rptr), 1);
    chk("sr_level2", 32'(level), 2);
    chk("sr_ae", 32'(almost_empty), 1);
    chk("sr_dv1", 32'(dout_valid), 1);
    step();
    chk("sr_dv2", 32'(dout_valid), 0);

    // Full and wrap
    do_reset();
    wptr = 5'd16;
    #1;
    chk("fw_full", 32'(fifo_full), 1);
    chk("fw_level", 32'(level), 16);
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("fw_dv", 32'(dout_valid), 1);
    end
    chk("fw_rptr16", 32'(rptr), 16);
    chk("fw_empty", 32'(fifo_empty), 1);
    rd = 1'b0;
    step();
    chk("fw_dv_off", 32'(dout_valid), 0);
    wptr = 5'd31;
    rd_n(15);
    chk("fw_rptr31", 32'(rptr), 31);
    wptr = 5'd0;
    rd_n(1);
    chk("fw_rptr0", 32'(rptr), 0);
    chk("fw_empty2", 32'(fifo_empty), 1);

    // Underflow
    do_reset();
    wptr = 5'd5;
    rd_n(5);
    rd = 1'b1;
    #1;
    chk("uf_re", 32'(fifo_re), 0);
    step();
    step();
    rd = 1'b0;
    chk("uf_rptr", 32'(rptr), 5);
    chk("uf_set", 32'(underflow), 1);
    step();
    chk("uf_sticky", 32'(underflow), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("uf_clr", 32'(underflow), 0);
    clr_err = 1'b1; rd = 1'b1;
    step();
    clr_err = 1'b0; rd = 1'b0;
    chk("uf_prio", 32'(underflow), 1);

    // Simultaneous read/write at empty
    do_reset();
    wptr = 5'd9;
    rd_n(9);
    rd = 1'b1;
    #1;
    chk("se_re", 32'(fifo_re), 0);
    step();
    wptr = 5'd10;
    #1;
    chk("se_rptr_hold", 32'(rptr), 9);
    chk("se_re2", 32'(fifo_re), 1);
    step();
    rd = 1'b0;
    chk("se_rptr", 32'(rptr), 10);
    chk("se_empty", 32'(fifo_empty), 1);

    // Simultaneous read/write at full
    do_reset();
    wptr = 5'd4;
    rd_n(4);
    wptr = 5'd20;
    rd = 1'b1;
    #1;
    chk("sf_full", 32'(fifo_full), 1);
    chk("sf_level", 32'(level), 16);
    step();
    rd = 1'b0;
    chk("sf_rptr", 32'(rptr), 5);
    chk("sf_level2", 32'(level), 15);
    chk("sf_full2", 32'(fifo_full), 0);

    // Random traffic against an occupancy model
    do_reset();
    occ = 0; exp_rptr = 0; prev_re = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1)) && (occ < 16);
      rd = r;
      exp_re = r && (occ > 0);
      #1;
      chk("rnd_level", 32'(level), 32'(occ));
      chk("rnd_empty", 32'(fifo_empty), 32'(occ == 0));
      chk("rnd_full", 32'(fifo_full), 32'(occ == 16));
      chk("rnd_ae", 32'(almost_empty), 32'(occ <= 2));
      chk("rnd_re", 32'(fifo_re), 32'(exp_re));
      chk("rnd_dv", 32'(dout_valid), 32'(prev_re));
      chk("rnd_rptr", 32'(rptr), 32'(exp_rptr));
      @(posedge clk);
      #1;
      if (w) wptr = wptr + 5'd1;
      occ = occ + int'(w) - int'(exp_re);
      if (exp_re) exp_rptr = (exp_rptr + 1) % 32;
      prev_re = exp_re;
    end
    rd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
